// File: rtl/sopc_v3_onchip_memory_arb_pkg.sv
// ----------------------------------------------------------------------------
// sopc_mem_pkg : shared types and helpers for the dual-port on-chip RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sopc_mem_pkg;

  typedef enum logic {
    S1 = 1'b0,
    S2 = 1'b1
  } port_id_t;

  localparam int RD_LAT_MAX = 2;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sopc_v3_onchip_memory_arb_if.sv
// ----------------------------------------------------------------------------
// sopc_v3_onchip_memory_arb_if : one Avalon-MM slave port of the shared RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sopc_v3_onchip_memory_arb_if
  import sopc_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) ();

  logic [ADDR_W-1:0]        address;
  logic [lanes(DATA_W)-1:0] byteenable;
  logic                     chipselect;
  logic                     read;
  logic                     write;
  logic [DATA_W-1:0]        writedata;
  logic                     waitrequest;
  logic [DATA_W-1:0]        readdata;
  logic                     readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

`default_nettype wire

// File: rtl/sopc_v3_onchip_memory_arb_ram.sv
// ----------------------------------------------------------------------------
// sopc_ram_sp_be : inferred single-port RAM, byte-lane writes, synchronous read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sopc_ram_sp_be
  import sopc_mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 5000,
  parameter int    ADDR_W    = 13,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "sopc_v3_onchip_memory_arb.hex"
) (
  input  wire logic                     clk,
  input  wire logic                     clken,
  input  wire logic [lanes(DATA_W)-1:0] we_i,
  input  wire logic                     re_i,
  input  wire logic [ADDR_W-1:0]        addr_i,
  input  wire logic [DATA_W-1:0]        wdata_i,
  output logic      [DATA_W-1:0]        rdata_o
);

  localparam int LANES = lanes(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // The image itself is attached by the device flow; this keeps the name bound.
  wire unused_init = (INIT_FILE != "");

  always_ff @(posedge clk) begin
    if (clken) begin
      for (int i = 0; i < LANES; i++) begin
        if (we_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
      if (re_i) rd_q <= mem_q[addr_i];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] oreg_q;
    always_ff @(posedge clk) begin
      if (clken) oreg_q <= rd_q;
    end
    assign rdata_o = oreg_q;
  end else begin : g_noreg
    assign rdata_o = rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/sopc_v3_onchip_memory_arb.sv
// ----------------------------------------------------------------------------
// sopc_v3_onchip_memory_arb : round-robin arbiter, range check and read tag pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sopc_v3_onchip_memory_arb
  import sopc_mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 5000,
  parameter int    ADDR_W    = 13,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "sopc_v3_onchip_memory_arb.hex"
) (
  input wire logic                          clk,
  input wire logic                          reset_n,
  input wire logic                          clken,
  sopc_v3_onchip_memory_arb_if.slave        s1,
  sopc_v3_onchip_memory_arb_if.slave        s2
);

  localparam int LANES = lanes(DATA_W);
  localparam int LAT   = (OUT_REG != 0) ? RD_LAT_MAX : 1;

  logic     req1, req2, gnt1, gnt2, any_gnt;
  port_id_t prio_q, prio_d, sel;

  assign req1    = s1.chipselect & (s1.read | s1.write);
  assign req2    = s2.chipselect & (s2.read | s2.write);
  assign gnt1    = clken & reset_n & req1 & (~req2 | (prio_q == S1));
  assign gnt2    = clken & reset_n & req2 & (~req1 | (prio_q == S2));
  assign any_gnt = gnt1 | gnt2;
  assign sel     = gnt2 ? S2 : S1;

  assign s1.waitrequest = (req1 & ~gnt1) | ~clken | ~reset_n;
  assign s2.waitrequest = (req2 & ~gnt2) | ~clken | ~reset_n;

  always_comb begin
    prio_d = prio_q;
    if (gnt1)      prio_d = S2;
    else if (gnt2) prio_d = S1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   prio_q <= S1;
    else if (clken) prio_q <= prio_d;
  end

  // Granted access; write wins over read when both qualifiers are high.
  logic [ADDR_W-1:0] addr;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wdata;
  logic              is_wr, in_range, rd_acc;
  logic [LANES-1:0]  ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign addr     = (sel == S2) ? s2.address    : s1.address;
  assign be       = (sel == S2) ? s2.byteenable : s1.byteenable;
  assign wdata    = (sel == S2) ? s2.writedata  : s1.writedata;
  assign is_wr    = (sel == S2) ? s2.write      : s1.write;
  assign in_range = 32'(addr) < DEPTH;
  assign rd_acc   = any_gnt & ~is_wr;
  assign ram_re   = rd_acc & in_range;
  assign ram_we   = (any_gnt & is_wr & in_range) ? be : '0;

  sopc_ram_sp_be #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .OUT_REG  (OUT_REG),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .clken  (clken),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(ram_rdata)
  );

  // Tag/valid pipe runs in lockstep with the RAM read path.
  logic [LAT-1:0] vld_q, oor_q;
  port_id_t       tag_q [LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      oor_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= S1;
    end else if (clken) begin
      vld_q[0] <= rd_acc;
      oor_q[0] <= ~in_range;
      tag_q[0] <= sel;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        oor_q[i] <= oor_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  logic [DATA_W-1:0] rdata_fin, hold1_q, hold2_q;
  logic              vout1, vout2;

  assign rdata_fin = oor_q[LAT-1] ? '0 : ram_rdata;
  assign vout1     = clken & vld_q[LAT-1] & (tag_q[LAT-1] == S1);
  assign vout2     = clken & vld_q[LAT-1] & (tag_q[LAT-1] == S2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      if (vout1) hold1_q <= rdata_fin;
      if (vout2) hold2_q <= rdata_fin;
    end
  end

  assign s1.readdatavalid = vout1;
  assign s2.readdatavalid = vout2;
  assign s1.readdata      = vout1 ? rdata_fin : hold1_q;
  assign s2.readdata      = vout2 ? rdata_fin : hold2_q;

endmodule

`default_nettype wire

// File: tb/tb_sopc_v3_onchip_memory_arb.sv
// ----------------------------------------------------------------------------
// tb_sopc_v3_onchip_memory_arb : drives OUT_REG=0 and OUT_REG=1 copies in lockstep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sopc_v3_onchip_memory_arb;

  localparam int DEPTH = 5000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  always #5 clk = ~clk;

  logic [12:0] a_v  [2];
  logic [3:0]  be_v [2];
  logic        cs_v [2];
  logic        rd_v [2];
  logic        wr_v [2];
  logic [31:0] wd_v [2];

  sopc_v3_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(13)) if_01 ();
  sopc_v3_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(13)) if_02 ();
  sopc_v3_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(13)) if_11 ();
  sopc_v3_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(13)) if_12 ();

  assign if_01.address = a_v[0];  assign if_11.address = a_v[0];
  assign if_02.address = a_v[1];  assign if_12.address = a_v[1];
  assign if_01.byteenable = be_v[0];  assign if_11.byteenable = be_v[0];
  assign if_02.byteenable = be_v[1];  assign if_12.byteenable = be_v[1];
  assign if_01.chipselect = cs_v[0];  assign if_11.chipselect = cs_v[0];
  assign if_02.chipselect = cs_v[1];  assign if_12.chipselect = cs_v[1];
  assign if_01.read = rd_v[0];  assign if_11.read = rd_v[0];
  assign if_02.read = rd_v[1];  assign if_12.read = rd_v[1];
  assign if_01.write = wr_v[0];  assign if_11.write = wr_v[0];
  assign if_02.write = wr_v[1];  assign if_12.write = wr_v[1];
  assign if_01.writedata = wd_v[0];  assign if_11.writedata = wd_v[0];
  assign if_02.writedata = wd_v[1];  assign if_12.writedata = wd_v[1];

  logic        w_o [2][2];
  logic        v_o [2][2];
  logic [31:0] r_o [2][2];

  assign w_o[0][0] = if_01.waitrequest;    assign w_o[0][1] = if_02.waitrequest;
  assign w_o[1][0] = if_11.waitrequest;    assign w_o[1][1] = if_12.waitrequest;
  assign v_o[0][0] = if_01.readdatavalid;  assign v_o[0][1] = if_02.readdatavalid;
  assign v_o[1][0] = if_11.readdatavalid;  assign v_o[1][1] = if_12.readdatavalid;
  assign r_o[0][0] = if_01.readdata;       assign r_o[0][1] = if_02.readdata;
  assign r_o[1][0] = if_11.readdata;       assign r_o[1][1] = if_12.readdata;

  sopc_v3_onchip_memory_arb #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(13), .OUT_REG(0),
    .INIT_FILE("sopc_v3_onchip_memory_arb.hex")) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .s1(if_01), .s2(if_02));

  sopc_v3_onchip_memory_arb #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(13), .OUT_REG(1),
    .INIT_FILE("sopc_v3_onchip_memory_arb.hex")) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .s1(if_11), .s2(if_12));

  // ---------------- reference model ----------------
  typedef struct {
    int          d;
    int          p;
    logic [31:0] data;
    int          due;
  } rd_t;

  logic [31:0] mem_m [int];
  rd_t         pend [$];
  int          prio_m = 0;
  int          ecnt = 0;
  logic [31:0] hold_m [2][2];
  int          obs_cnt [2][2];
  logic [31:0] obs_last [2][2];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        hold_m[d][p]   = '0;
        obs_cnt[d][p]  = 0;
        obs_last[d][p] = '0;
      end
  end

  always @(negedge clk) begin : b_cmp
    logic        req [2];
    logic        gnt [2];
    logic        ev;
    logic [31:0] ed, cur;
    rd_t         e;
    int          adr;
    if (!reset_n) begin
      pend.delete();
      prio_m = 0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          hold_m[d][p] = '0;
          chk($sformatf("rst d%0d s%0d wait", d, p + 1), 32'(w_o[d][p]), 32'd1);
          chk($sformatf("rst d%0d s%0d valid", d, p + 1), 32'(v_o[d][p]), 32'd0);
          chk($sformatf("rst d%0d s%0d rdata", d, p + 1), r_o[d][p], 32'd0);
        end
    end else if (!clken) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("noclk d%0d s%0d wait", d, p + 1), 32'(w_o[d][p]), 32'd1);
          chk($sformatf("noclk d%0d s%0d valid", d, p + 1), 32'(v_o[d][p]), 32'd0);
          chk($sformatf("noclk d%0d s%0d rdata", d, p + 1), r_o[d][p], hold_m[d][p]);
        end
    end else begin
      for (int p = 0; p < 2; p++) req[p] = cs_v[p] & (rd_v[p] | wr_v[p]);
      gnt[0] = req[0] && (!req[1] || prio_m == 0);
      gnt[1] = req[1] && (!req[0] || prio_m == 1);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          ev = 1'b0;
          ed = hold_m[d][p];
          for (int i = 0; i < pend.size(); i++)
            if (pend[i].d == d && pend[i].p == p && pend[i].due == ecnt) begin
              ev = 1'b1;
              ed = pend[i].data;
            end
          chk($sformatf("d%0d s%0d wait", d, p + 1), 32'(w_o[d][p]), 32'(req[p] & ~gnt[p]));
          chk($sformatf("d%0d s%0d valid", d, p + 1), 32'(v_o[d][p]), 32'(ev));
          chk($sformatf("d%0d s%0d rdata", d, p + 1), r_o[d][p], ed);
          hold_m[d][p] = ed;
          if (v_o[d][p] === 1'b1) begin
            obs_cnt[d][p]++;
            obs_last[d][p] = r_o[d][p];
          end
        end
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == ecnt) pend.delete(i);
      for (int p = 0; p < 2; p++) begin
        if (gnt[p]) begin
          adr = int'(a_v[p]);
          cur = mem_m.exists(adr) ? mem_m[adr] : 32'd0;
          if (wr_v[p]) begin
            if (adr < DEPTH) begin
              for (int l = 0; l < 4; l++)
                if (be_v[p][l]) cur[l*8 +: 8] = wd_v[p][l*8 +: 8];
              if (be_v[p] != 4'h0) mem_m[adr] = cur;
            end
          end else begin
            for (int d = 0; d < 2; d++) begin
              e.d    = d;
              e.p    = p;
              e.data = (adr < DEPTH) ? cur : 32'd0;
              e.due  = ecnt + 1 + d;
              pend.push_back(e);
            end
          end
          prio_m = (p == 0) ? 1 : 0;
        end
      end
      ecnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs_v[p] = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
      a_v[p] = '0; be_v[p] = '0; wd_v[p] = '0;
    end
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d, input logic [3:0] b);
    cs_v[p] = 1'b1; rd_v[p] = 1'b0; wr_v[p] = 1'b1;
    a_v[p] = 13'(a); wd_v[p] = d; be_v[p] = b;
  endtask

  task automatic set_rd(input int p, input int a);
    cs_v[p] = 1'b1; rd_v[p] = 1'b1; wr_v[p] = 1'b0;
    a_v[p] = 13'(a); wd_v[p] = '0; be_v[p] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : b_main
    int base [2];
    idle();
    repeat (3) tick();
    reset_n = 1'b1;

    // single-port write then read
    set_wr(0, 5, 32'hDEADBEEF, 4'hF); tick();
    set_wr(0, 4999, 32'hCAFEF00D, 4'hF); tick();
    set_rd(0, 5); tick();
    idle(); repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("basic d%0d s1 data", d), obs_last[d][0], 32'hDEADBEEF);
      chk($sformatf("basic d%0d s1 count", d), 32'(obs_cnt[d][0]), 32'd1);
      chk($sformatf("basic d%0d s2 count", d), 32'(obs_cnt[d][1]), 32'd0);
    end

    // byte lanes
    set_wr(0, 7, 32'h11223344, 4'hF); tick();
    idle(); set_wr(1, 7, 32'hAABBCCDD, 4'h5); tick();
    idle(); set_rd(1, 7); tick();
    idle(); repeat (3) tick();
    chk("lanes model", mem_m[7], 32'h11BB33DD);
    for (int d = 0; d < 2; d++)
      chk($sformatf("lanes d%0d s2 data", d), obs_last[d][1], 32'h11BB33DD);

    // contention from reset
    reset_n = 1'b0; repeat (2) tick();
    reset_n = 1'b1;
    base[0] = obs_cnt[1][0]; base[1] = obs_cnt[1][1];
    set_rd(0, 5); set_rd(1, 7);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d d0 s1 wait", i), 32'(if_01.waitrequest), 32'(i % 2));
      chk($sformatf("cont%0d d0 s2 wait", i), 32'(if_02.waitrequest), 32'((i + 1) % 2));
      chk($sformatf("cont%0d d1 s1 wait", i), 32'(if_11.waitrequest), 32'(i % 2));
      chk($sformatf("cont%0d d1 s2 wait", i), 32'(if_12.waitrequest), 32'((i + 1) % 2));
      tick();
    end
    idle(); repeat (3) tick();
    chk("cont d1 s1 count", 32'(obs_cnt[1][0] - base[0]), 32'd2);
    chk("cont d1 s2 count", 32'(obs_cnt[1][1] - base[1]), 32'd2);
    chk("cont d1 s1 data", obs_last[1][0], 32'hDEADBEEF);
    chk("cont d0 s2 data", obs_last[0][1], 32'h11BB33DD);

    // out of range
    set_wr(0, 5000, 32'h12345678, 4'hF); set_rd(1, 6000); repeat (2) tick();
    idle(); repeat (3) tick();
    chk("oor model size", 32'(mem_m.size()), 32'd3);
    for (int d = 0; d < 2; d++)
      chk($sformatf("oor d%0d s2 data", d), obs_last[d][1], 32'd0);
    set_rd(0, 5); tick();
    set_rd(0, 7); tick();
    set_rd(0, 4999); tick();
    idle(); repeat (3) tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("oor d%0d 4999 data", d), obs_last[d][0], 32'hCAFEF00D);

    // clock enable stall
    set_rd(0, 5); tick();
    idle(); clken = 1'b0; set_rd(1, 7);
    base[0] = obs_cnt[0][0]; base[1] = obs_cnt[1][0];
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d d0 s1 wait", i), 32'(if_01.waitrequest), 32'd1);
      chk($sformatf("stall%0d d0 s2 wait", i), 32'(if_02.waitrequest), 32'd1);
      chk($sformatf("stall%0d d1 s2 wait", i), 32'(if_12.waitrequest), 32'd1);
      chk($sformatf("stall%0d d1 s1 valid", i), 32'(if_11.readdatavalid), 32'd0);
      tick();
    end
    clken = 1'b1; idle(); repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall d%0d s1 count", d), 32'(obs_cnt[d][0] - base[d]), 32'd1);
      chk($sformatf("stall d%0d s1 data", d), obs_last[d][0], 32'hDEADBEEF);
    end

    // reset with a read in flight
    set_wr(0, 9, 32'h0BADF00D, 4'hF); tick();
    set_rd(0, 9); tick();
    reset_n = 1'b0; idle();
    base[0] = obs_cnt[0][0]; base[1] = obs_cnt[1][0];
    repeat (2) tick();
    reset_n = 1'b1; repeat (3) tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("rstmid d%0d s1 count", d), 32'(obs_cnt[d][0] - base[d]), 32'd0);
    set_rd(0, 9); set_rd(1, 7); #1;
    chk("rstmid d1 prio s1 wait", 32'(if_11.waitrequest), 32'd0);
    chk("rstmid d1 prio s2 wait", 32'(if_12.waitrequest), 32'd1);
    chk("rstmid d0 prio s2 wait", 32'(if_02.waitrequest), 32'd1);
    tick();
    idle(); repeat (4) tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("rstmid d%0d data kept", d), obs_last[d][0], 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
